// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle MUL/DIVU/REMU sequencer.
//   - request op encodings (md_op_e)
//   - ALU control encodings of the shared 32-bit combinational ALU
//   - sequencer state enum (state_e)
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_DIVU = 2'b01,
    MD_REMU = 2'b10,
    MD_RSVD = 2'b11
  } md_op_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_STEP,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_alu_sequencer.sv
// muldiv_alu_sequencer: computes MUL (low 32 bits), DIVU and REMU by driving
// the shared combinational ALU one step per clock.
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_op/req_a/req_b  op (00 MUL, 01 DIVU, 10 REMU, 11 reserved) and operands
//   resp_valid/ready    response handshake; resp_result held stable in DONE
//   alu_own             high while this block drives the ALU (MUL_STEP/DIV_*)
//   alu_ctrl/a/b        ALU control and operands (ADD/0/0 when not owned)
//   alu_result          combinational ALU result
// Optional: `define MULDIV_EARLY_EXIT_EN ends MUL once no multiplier bits
// above the current step remain set (same result, shorter latency).
module muldiv_alu_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            alu_own,
  output logic [2:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result
);

  state_e          state, state_n;
  md_op_e          op_q, op_n;
  logic [XLEN-1:0] mcand, mcand_n;   // multiplicand
  logic [XLEN-1:0] mplier, mplier_n; // multiplier, or divisor
  logic [XLEN-1:0] acc, acc_n;
  logic [XLEN-1:0] quot, quot_n;
  logic [XLEN-1:0] rem, rem_n;
  logic [XLEN-1:0] shreg, shreg_n;   // shifted remainder held for DIV_SUB
  logic [XLEN-1:0] result, result_n;
  logic [4:0]      cnt, cnt_n;

  logic [XLEN-1:0] shifted;
  logic            carry;
  logic [XLEN-1:0] acc_step;
  logic            mul_last;
  logic            cnt_last;

  assign shifted  = {rem[XLEN-2:0], quot[XLEN-1]};
  assign carry    = rem[XLEN-1];
  assign cnt_last = (cnt == 5'd31);

  always_comb begin
    acc_step = mplier[cnt] ? alu_result : acc;
`ifdef MULDIV_EARLY_EXIT_EN
    mul_last = cnt_last || (((mplier >> cnt) >> 1) == '0);
`else
    mul_last = cnt_last;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= MD_MUL;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      quot   <= '0;
      rem    <= '0;
      shreg  <= '0;
      result <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      quot   <= quot_n;
      rem    <= rem_n;
      shreg  <= shreg_n;
      result <= result_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    quot_n   = quot;
    rem_n    = rem;
    shreg_n  = shreg;
    result_n = result;
    cnt_n    = cnt;
    alu_own  = 1'b0;
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          op_n     = md_op_e'(req_op);
          mcand_n  = req_a;
          mplier_n = req_b;
          cnt_n    = '0;
          case (md_op_e'(req_op))
            MD_MUL: begin
              acc_n   = '0;
              state_n = S_MUL_STEP;
            end
            MD_DIVU, MD_REMU: begin
              if (req_b != '0) begin
                quot_n  = req_a;
                rem_n   = '0;
                state_n = S_DIV_CMP;
              end else begin
                result_n = (md_op_e'(req_op) == MD_DIVU) ? '1 : req_a;
                state_n  = S_DONE;
              end
            end
            default: begin
              result_n = '0;
              state_n  = S_DONE;
            end
          endcase
        end
      end

      S_MUL_STEP: begin
        alu_own = 1'b1;
        alu_a   = acc;
        alu_b   = mcand << cnt;
        acc_n   = acc_step;
        cnt_n   = cnt + 5'd1;
        if (mul_last) begin
          result_n = acc_step;
          state_n  = S_DONE;
        end
      end

      // A set carry means the shifted remainder is >= divisor, so the
      // compare is skipped and the wrapped subtract in DIV_SUB is exact.
      S_DIV_CMP: begin
        alu_own = 1'b1;
        quot_n  = quot << 1;
        shreg_n = shifted;
        if (carry) begin
          state_n = S_DIV_SUB;
        end else begin
          alu_ctrl = ALU_SLTU;
          alu_a    = shifted;
          alu_b    = mplier;
          if (alu_result[0]) begin
            rem_n = shifted;
            cnt_n = cnt + 5'd1;
            if (cnt_last) begin
              result_n = (op_q == MD_DIVU) ? (quot << 1) : shifted;
              state_n  = S_DONE;
            end
          end else begin
            state_n = S_DIV_SUB;
          end
        end
      end

      S_DIV_SUB: begin
        alu_own   = 1'b1;
        alu_ctrl  = ALU_SUB;
        alu_a     = shreg;
        alu_b     = mplier;
        rem_n     = alu_result;
        quot_n[0] = 1'b1;
        cnt_n     = cnt + 5'd1;
        if (cnt_last) begin
          result_n = (op_q == MD_DIVU) ? {quot[XLEN-1:1], 1'b1} : alu_result;
          state_n  = S_DONE;
        end else begin
          state_n = S_DIV_CMP;
        end
      end

      S_DONE: begin
        if (resp_ready) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign req_ready   = (state == S_IDLE);
  assign resp_valid  = (state == S_DONE);
  assign resp_result = result;

endmodule

// File: tb/tb_muldiv_alu_sequencer.sv
// tb_muldiv_alu_sequencer: randomized and directed self-checking bench for
// muldiv_alu_sequencer. Provides the shared ALU behaviourally and predicts
// results and latencies from plain arithmetic.
module tb_muldiv_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        alu_own;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  muldiv_alu_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .alu_own    (alu_own),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  // Shared ALU
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [1:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
    case (op)
      2'b00:   return a * b;
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Clock edges from the accept edge until resp_valid is first visible.
  // Division pays one extra cycle for every quotient bit that is 1.
  function automatic int unsigned model_lat(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned n;
    logic [31:0] q;
    if (op == 2'b00) begin
`ifdef MULDIV_EARLY_EXIT_EN
      n = 1;
      for (int unsigned i = 0; i < 32; i++) if (b[i]) n = i + 1;
      return n;
`else
      return 32;
`endif
    end
    if (op == 2'b11 || b == 0) return 0;
    q = a / b;
    n = 32;
    for (int unsigned i = 0; i < 32; i++) if (q[i]) n++;
    return n;
  endfunction

  // Issues one request at the current negedge, waits for the response,
  // holds resp_ready low for 'hold' DONE cycles, then retires it.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned hold);
    logic [31:0] exp_r;
    logic [31:0] first_r;
    int unsigned lat;
    logic owned, bad_ctrl, unstable, rdy_in_done;
    exp_r = model_result(op, a, b);
    lat = 0;
    while (!req_ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    lat = 0;
    owned = 1'b0;
    bad_ctrl = 1'b0;
    while (!resp_valid && lat < 100) begin
      if (alu_own) owned = 1'b1;
      if (op == 2'b00 && alu_ctrl != 3'b000) bad_ctrl = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("lat op%0d", op), lat, model_lat(op, a, b));
    chk($sformatf("result op%0d a=%h b=%h", op, a, b), resp_result, exp_r);
    if (op == 2'b00) chk("mul_ctrl_add", {31'd0, bad_ctrl}, 32'd0);
    if (op == 2'b11 || (op != 2'b00 && b == 0)) chk("no_alu_own", {31'd0, owned}, 32'd0);
    if (hold > 0) begin
      first_r = resp_result;
      unstable = 1'b0;
      rdy_in_done = 1'b0;
      for (int unsigned i = 0; i < hold; i++) begin
        @(negedge clk);
        if (resp_result !== first_r || !resp_valid) unstable = 1'b1;
        if (req_ready) rdy_in_done = 1'b1;
      end
      chk("hold_stable", {31'd0, unstable}, 32'd0);
      chk("hold_req_ready", {31'd0, rdy_in_done}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int unsigned wait_n;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst req_ready",   {31'd0, req_ready},  32'd1);
    chk("rst resp_valid",  {31'd0, resp_valid}, 32'd0);
    chk("rst resp_result", resp_result,         32'd0);
    chk("rst alu_own",     {31'd0, alu_own},    32'd0);
    chk("rst alu_ctrl",    {29'd0, alu_ctrl},   32'd0);
    chk("rst alu_a",       alu_a,               32'd0);
    chk("rst alu_b",       alu_b,               32'd0);

    // Directed cases
    run_op(2'b00, 32'd7, 32'd6, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'd5, 32'd1, 0);
    run_op(2'b01, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'd100, 32'd7, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(2'b01, 32'd123, 32'd0, 0);
    run_op(2'b10, 32'd123, 32'd0, 0);
    run_op(2'b11, 32'd55, 32'd66, 0);
    // Long DONE hold, then an immediate back-to-back request
    run_op(2'b01, 32'd1000, 32'd9, 10);
    run_op(2'b00, 32'd11, 32'd13, 0);

    // Reset in the middle of a division, while a subtract step is driven
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_n = 0;
    while (!(alu_own && alu_ctrl == 3'b001) && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    chk("reach_div_sub", {31'd0, alu_own && alu_ctrl == 3'b001}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst req_ready",   {31'd0, req_ready},  32'd1);
    chk("midrst resp_valid",  {31'd0, resp_valid}, 32'd0);
    chk("midrst alu_own",     {31'd0, alu_own},    32'd0);
    chk("midrst resp_result", resp_result,         32'd0);
    run_op(2'b00, 32'd3, 32'd4, 0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = $urandom;
        1:       r_b = $urandom_range(0, 15);
        2:       r_b = 32'd0;
        default: r_b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(r_op, r_a, r_b, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
